// File: rtl/regfile_sb.sv
// Parametrised integer register file with a post-reset clear sweep, optional
// write-to-read bypass and a per-register busy scoreboard (issue sets, writeback clears).
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_a
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [NREG-1:0] busy_reg, busy_next;
  logic [XLEN-1:0] rf [NREG];

  logic            wr_ok, iss_ok;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: the counter parks on the last register once READY is reached
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (cnt_reg == AW'(NREG - 1)) begin
          state_next = READY;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    if (state_reg == READY) begin
      ready = 1'b1;
    end
  end

  assign wr_ok  = ready && we3 && !(ZERO_REG && (a3 == '0));
  assign iss_ok = ready && iss_en && !(ZERO_REG && (iss_a == '0));

  // Single write port shared by the clear sweep and writeback
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a3;
    wr_data = wd3;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt_reg;
        wr_data = '0;
      end else if (wr_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // Busy scoreboard: an issue in the same cycle as a writeback wins (new producer)
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    logic set_bit, clr_bit;
    assign set_bit = iss_ok && (iss_a == AW'(gi));
    assign clr_bit = wr_ok && (a3 == AW'(gi));
    assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Combinational read ports, masked to zero until the sweep has finished
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            hit_zero, hit_byp;

    assign addr     = (gi == 0) ? a1 : a2;
    assign hit_zero = ZERO_REG && (addr == '0);
    assign hit_byp  = BYPASS && we3 && (addr == a3);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (ready && !hit_zero) begin
        if (hit_byp) begin
          data = wd3;
        end else begin
          data = rf[addr];
          busy = busy_reg[addr];
        end
      end
    end
  end

  assign rd1   = g_rd[0].data;
  assign busy1 = g_rd[0].busy;
  assign rd2   = g_rd[1].data;
  assign busy2 = g_rd[1].busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing instance share
// stimulus; expected outputs come from an array-based model of the register file.
module tb_regfile_sb;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  a1 = '0, a2 = '0, a3 = '0, iss_a = '0;
  logic        we3 = 1'b0, iss_en = 1'b0;
  logic [31:0] wd3 = '0;

  logic        ready_b, busy1_b, busy2_b, ready_n, busy1_n, busy2_n;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(N), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b), .busy1(busy1_b), .busy2(busy2_b),
    .we3(we3), .a3(a3), .wd3(wd3), .iss_en(iss_en), .iss_a(iss_a)
  );

  regfile_sb #(.XLEN(32), .NREG(N), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .ready(ready_n),
    .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n), .busy1(busy1_n), .busy2(busy2_n),
    .we3(we3), .a3(a3), .wd3(wd3), .iss_en(iss_en), .iss_a(iss_a)
  );

  typedef struct {
    string       tag;
    logic        rdy;
    logic [31:0] rd1b, rd2b, rd1n, rd2n;
    logic        b1b, b2b, b1n, b2n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Reference model: register contents, busy flags and edges since reset release
  logic [31:0] rf_m [N];
  bit          busy_m [N];
  int          since_rst = 0;
  bit          ready_m = 1'b0;

  task automatic model_edge();
    if (rst) begin
      since_rst = 0;
      ready_m   = 1'b0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
    end else if (!ready_m) begin
      since_rst++;
      if (since_rst == N) begin
        ready_m = 1'b1;
        foreach (rf_m[i]) rf_m[i] = '0;
      end
    end else begin
      if (we3 && a3 != 0) begin
        rf_m[a3]   = wd3;
        busy_m[a3] = 1'b0;
      end
      if (iss_en && iss_a != 0) busy_m[iss_a] = 1'b1;
    end
  endtask

  task automatic exp_port(input logic [4:0] a, input bit byp,
                          output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (ready_m && a != 0) begin
      if (byp && we3 && a3 == a) begin
        d = wd3;
      end else begin
        d = rf_m[a];
        b = busy_m[a];
      end
    end
  endtask

  // One cycle: commit the previous inputs to the model at the edge, then apply new ones
  task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit ie, input logic [4:0] ia,
                      input logic [4:0] ra1, input logic [4:0] ra2, input string tag);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; we3 = w; a3 = wa; wd3 = wd; iss_en = ie; iss_a = ia; a1 = ra1; a2 = ra2;
    e.tag = tag;
    e.rdy = ready_m;
    exp_port(ra1, 1'b1, e.rd1b, e.b1b);
    exp_port(ra2, 1'b1, e.rd2b, e.b2b);
    exp_port(ra1, 1'b0, e.rd1n, e.b1n);
    exp_port(ra2, 1'b0, e.rd2n, e.b2n);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2, input string tag);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra1, ra2, tag);
  endtask

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d %s a1=%0d a2=%0d rdy=%b rd1=%h/%h b1=%b/%b rd2=%h/%h b2=%b/%b",
                 n_txn, e.tag, a1, a2, ready_b, rd1_b, rd1_n, busy1_b, busy1_n,
                 rd2_b, rd2_n, busy2_b, busy2_n);
        chk(e.tag, "ready_byp",  32'(ready_b), 32'(e.rdy));
        chk(e.tag, "ready_nobyp", 32'(ready_n), 32'(e.rdy));
        chk(e.tag, "rd1_byp",    rd1_b, e.rd1b);
        chk(e.tag, "rd2_byp",    rd2_b, e.rd2b);
        chk(e.tag, "busy1_byp",  32'(busy1_b), 32'(e.b1b));
        chk(e.tag, "busy2_byp",  32'(busy2_b), 32'(e.b2b));
        chk(e.tag, "rd1_nobyp",  rd1_n, e.rd1n);
        chk(e.tag, "rd2_nobyp",  rd2_n, e.rd2n);
        chk(e.tag, "busy1_nobyp", 32'(busy1_n), 32'(e.b1n));
        chk(e.tag, "busy2_nobyp", 32'(busy2_n), 32'(e.b2n));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          r, w, ie;
    logic [4:0]  wa, ia, ra1, ra2;
    logic [31:0] wd;

    // Reset, then a partial sweep interrupted by a second reset
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2, "reset");
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2, "reset");
    for (int i = 0; i < 10; i++) idle(5'd3, 5'd9, "sweep");
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2, "rst_mid");

    // Full sweep with writes/issues to x9 that must be discarded
    for (int i = 0; i < 34; i++) begin
      if (i % 3 == 1) step(1'b0, 1'b1, 5'd9, 32'hCAFE0000 + 32'(i), 1'b1, 5'd9, 5'd9, 5'd31, "pre_ready");
      else            idle(5'd9, 5'd0, "pre_ready");
    end
    for (int i = 0; i < N; i++) idle(5'(i), 5'((i + 16) % N), "cleared");

    // Write latency with and without bypass
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd4, "wr_x5");
    idle(5'd5, 5'd5, "rd_x5");
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd7, "byp_x7");
    idle(5'd7, 5'd7, "rd_x7");

    // x0 protection
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, "x0_wr");
    idle(5'd0, 5'd0, "x0_rd");

    // Scoreboard: issue, issue+write collision, writeback alone
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3, "iss_x3");
    idle(5'd3, 5'd3, "busy_x3");
    step(1'b0, 1'b1, 5'd3, 32'h000000A5, 1'b1, 5'd3, 5'd3, 5'd2, "wr_iss_x3");
    idle(5'd3, 5'd3, "after_coll");
    step(1'b0, 1'b1, 5'd3, 32'h0000005A, 1'b0, 5'd0, 5'd3, 5'd1, "wb_x3");
    idle(5'd3, 5'd3, "free_x3");

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(149, 0) == 0);
      w   = $urandom_range(1, 0);
      wa  = 5'($urandom_range(N - 1, 0));
      wd  = $urandom;
      ie  = ($urandom_range(2, 0) == 0);
      ia  = ($urandom_range(1, 0) == 0) ? wa : 5'($urandom_range(N - 1, 0));
      ra1 = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom_range(N - 1, 0));
      ra2 = ($urandom_range(2, 0) == 0) ? ia : 5'($urandom_range(N - 1, 0));
      step(r, w, wa, wd, ie, ia, ra1, ra2, "rand");
    end

    idle(5'd1, 5'd2, "tail");
    @(posedge clk);
    @(posedge clk);
    chk("end", "queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
